// File: rtl/audio_pwm_bank.sv
// audio_pwm_bank -- bank of per-channel audio PWM generators, an optional
// mixed-sum PWM, a period-start strobe and a fractional-rate tick enable.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   ch_in        NUM_CH samples, channel i at [i*IN_BITS +: IN_BITS]
//   mute         per-channel mute, 1 = channel contributes 0
//   pwm_out      per-channel registered PWM
//   mix_pwm      registered PWM of the sum of all channels
//   frame_start  high in the cycle where the period counter is 0
//   gb_tick      one-cycle enable on each phase-accumulator overflow
//
// Build option: define AUDIO_PWM_MIX_EN to build the mixer; otherwise
// mix_pwm is tied low and no mixer logic exists.
//
// Samples are captured into shadow registers in the last cycle of each
// period, so a channel's duty cycle only changes on period boundaries.

module audio_pwm_bank #(
   parameter int NUM_CH   = 4,
   parameter int IN_BITS  = 4,
   parameter int PERIOD   = 2048,
   parameter int ACC_BITS = 24,
   parameter int TICK_INC = 562950
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH*IN_BITS-1:0] ch_in,
   input  logic [NUM_CH-1:0]         mute,
   output logic [NUM_CH-1:0]         pwm_out,
   output logic                      mix_pwm,
   output logic                      frame_start,
   output logic                      gb_tick
);

   localparam int CNT_W    = $clog2(PERIOD);
   localparam int THR_W    = CNT_W + 1;
   localparam int MIX_BITS = IN_BITS + $clog2(NUM_CH);
   localparam int STEP     = PERIOD >> IN_BITS;
   localparam int MSTEP    = PERIOD >> MIX_BITS;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [ACC_BITS:0] ACC_INC  = (ACC_BITS + 1)'(TICK_INC);

   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [NUM_CH-1:0][IN_BITS-1:0]  shadow_q, shadow_d;
   logic [NUM_CH-1:0]               pwm_q, pwm_d;
   logic [ACC_BITS-1:0]             acc_q;
   logic [ACC_BITS:0]               acc_sum;
   logic                            gb_q;
   logic                            last_cyc;
   logic [THR_W-1:0]                thr;

   assign last_cyc = (cnt_q == CNT_LAST);
   assign acc_sum  = {1'b0, acc_q} + ACC_INC;

   always_comb begin
      cnt_d    = last_cyc ? '0 : cnt_q + CNT_W'(1);
      shadow_d = shadow_q;
      pwm_d    = '0;
      thr      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (last_cyc) begin
            shadow_d[i] = mute[i] ? '0 : ch_in[i*IN_BITS +: IN_BITS];
         end
         // Compare against the old count so the output rises one cycle
         // after the counter wraps and stays high for exactly thr cycles.
         thr      = THR_W'(shadow_q[i]) * THR_W'(STEP);
         pwm_d[i] = ({1'b0, cnt_q} < thr);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         pwm_q    <= '0;
         acc_q    <= '0;
         gb_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         pwm_q    <= pwm_d;
         acc_q    <= acc_sum[ACC_BITS-1:0];
         gb_q     <= acc_sum[ACC_BITS];
      end
   end

   assign pwm_out = pwm_q;
   assign gb_tick = gb_q;

   // The counter sits at 0 throughout reset; gating with reset keeps the
   // strobe quiet while held, and lets it fire in the first free cycle.
   assign frame_start = (cnt_q == '0) & ~reset;

`ifdef AUDIO_PWM_MIX_EN
   logic [MIX_BITS-1:0] mix_sum;
   logic [THR_W-1:0]    mix_thr;
   logic                mix_q;

   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mix_sum = mix_sum + MIX_BITS'(shadow_q[i]);
      end
      mix_thr = THR_W'(mix_sum) * THR_W'(MSTEP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mix_q <= 1'b0;
      end else begin
         mix_q <= ({1'b0, cnt_q} < mix_thr);
      end
   end

   assign mix_pwm = mix_q;
`else
   assign mix_pwm = 1'b0;
`endif

endmodule

// File: tb/tb_audio_pwm_bank.sv
module tb_audio_pwm_bank;

   localparam int NCH  = 4;
   localparam int INB  = 4;
   localparam int PER  = 64;
   localparam int STEP = 4;
   localparam int MSTP = 1;
   localparam int INC1 = 64;
   localparam int INC2 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [NCH*INB-1:0] ch_in;
   logic [NCH-1:0]    mute;
   logic [NCH-1:0]    pwm_out, pwm_out2;
   logic              mix_pwm, mix_pwm2;
   logic              frame_start, frame_start2;
   logic              gb_tick, gb_tick2;

   audio_pwm_bank #(.NUM_CH(NCH), .IN_BITS(INB), .PERIOD(PER),
                    .ACC_BITS(8), .TICK_INC(INC1)) dut (
      .clk(clk), .reset(reset), .ch_in(ch_in), .mute(mute),
      .pwm_out(pwm_out), .mix_pwm(mix_pwm),
      .frame_start(frame_start), .gb_tick(gb_tick));

   audio_pwm_bank #(.NUM_CH(NCH), .IN_BITS(INB), .PERIOD(PER),
                    .ACC_BITS(8), .TICK_INC(INC2)) dut2 (
      .clk(clk), .reset(reset), .ch_in(ch_in), .mute(mute),
      .pwm_out(pwm_out2), .mix_pwm(mix_pwm2),
      .frame_start(frame_start2), .gb_tick(gb_tick2));

   int checks = 0;
   int errors = 0;

   // Reference model: position in period, cycles since release, and the
   // sample value in force for the current period of each channel.
   int m_cnt;
   int m_n;
   int m_sh [NCH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Overflow of an 8-bit accumulator after n additions of inc.
   function automatic logic carry_at(input int n, input int inc);
      if (n < 1) return 1'b0;
      return ((n * inc) / 256) != (((n - 1) * inc) / 256);
   endfunction

   task automatic tick();
      logic [NCH-1:0] pwm_e;
      logic           mix_e;
      int             sum;
      @(posedge clk);
      if (reset) begin
         m_cnt = 0;
         m_n   = 0;
         for (int i = 0; i < NCH; i++) m_sh[i] = 0;
      end else begin
         if (m_cnt == PER - 1) begin
            for (int i = 0; i < NCH; i++)
               m_sh[i] = mute[i] ? 0 : int'(ch_in[i*INB +: INB]);
         end
         m_cnt = (m_cnt + 1) % PER;
         m_n++;
      end
      @(negedge clk);
      sum = 0;
      for (int i = 0; i < NCH; i++) begin
         pwm_e[i] = (m_cnt >= 1) && (m_cnt <= m_sh[i] * STEP);
         sum += m_sh[i];
      end
`ifdef AUDIO_PWM_MIX_EN
      mix_e = (m_cnt >= 1) && (m_cnt <= sum * MSTP);
`else
      mix_e = 1'b0;
`endif
      chk("pwm_out", 32'(pwm_out), 32'(pwm_e));
      chk("mix_pwm", 32'(mix_pwm), 32'(mix_e));
      chk("frame_start", 32'(frame_start), 32'((m_cnt == 0) && !reset));
      chk("gb_tick_inc64", 32'(gb_tick), 32'(carry_at(m_n, INC1)));
      chk("gb_tick_inc3", 32'(gb_tick2), 32'(carry_at(m_n, INC2)));
   endtask

   task automatic run_period(output int h0, output int h1, output int hm);
      h0 = 0; h1 = 0; hm = 0;
      for (int k = 0; k < PER; k++) begin
         tick();
         h0 += int'(pwm_out[0]);
         h1 += int'(pwm_out[1]);
         hm += int'(mix_pwm);
      end
   endtask

   initial begin
      int h0, h1, hm, g1, g2, first_gb;
`ifdef AUDIO_PWM_MIX_EN
      int exp60 = 60, exp45 = 45;
`else
      int exp60 = 0, exp45 = 0;
`endif
      m_cnt = 0; m_n = 0;
      for (int i = 0; i < NCH; i++) m_sh[i] = 0;
      ch_in = '0; mute = '0; reset = 1'b1;
      repeat (3) tick();
      chk("reset_pwm_zero", 32'(pwm_out), 0);
      reset = 1'b0;
      #1;
      chk("release_frame_start", 32'(frame_start), 1);

      // ch0 = 8: first period all low, then 32 high cycles
      ch_in = 16'h0008;
      run_period(h0, h1, hm);
      chk("first_period_low", h0, 0);
      run_period(h0, h1, hm);
      chk("ch8_high_32", h0, 32);
      chk("ch8_other_low", h1, 0);

      // ch0 = 15, ch1 = 0
      ch_in = 16'h000F;
      run_period(h0, h1, hm);
      run_period(h0, h1, hm);
      chk("ch15_high_60", h0, 60);
      chk("ch1_zero_never", h1, 0);

      // change 8 -> 4 mid-period takes effect only next period
      ch_in = 16'h0008;
      run_period(h0, h1, hm);
      h0 = 0;
      for (int k = 0; k < PER; k++) begin
         tick();
         h0 += int'(pwm_out[0]);
         if (m_cnt == 20) ch_in = 16'h0004;
      end
      chk("midchange_keeps_32", h0, 32);
      run_period(h0, h1, hm);
      chk("midchange_next_16", h0, 16);

      // all channels 15, then mute ch0 only in the latch cycle
      ch_in = 16'hFFFF;
      run_period(h0, h1, hm);
      hm = 0;
      for (int k = 0; k < PER; k++) begin
         tick();
         hm += int'(mix_pwm);
         mute = (m_cnt == PER - 1) ? 4'b0001 : 4'b0000;
      end
      chk("mix_all15", hm, exp60);
      run_period(h0, h1, hm);
      chk("mix_ch0_muted", hm, exp45);
      chk("muted_ch0_low", h0, 0);
      chk("unmuted_ch1_60", h1, 60);

      // randomized inputs checked cycle by cycle against the model
      for (int p = 0; p < 6; p++) begin
         for (int k = 0; k < PER; k++) begin
            tick();
            if ($urandom_range(0, 7) == 0) ch_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) mute = 4'($urandom);
         end
      end
      mute = '0;

      // reset at cnt = 30 while ch0 is high
      ch_in = 16'h0008;
      run_period(h0, h1, hm);
      for (int k = 0; k < PER && m_cnt != 30; k++) tick();
      chk("pwm0_high_at_30", 32'(pwm_out[0]), 1);
      reset = 1'b1;
      tick();
      chk("midreset_pwm_zero", 32'(pwm_out), 0);
      chk("midreset_gb_zero", 32'(gb_tick), 0);
      reset = 1'b0;
      #1;
      chk("rerelease_frame_start", 32'(frame_start), 1);

      // tick rates over 256 cycles after release; first period all low
      h0 = 0; g1 = 0; g2 = 0; first_gb = -1;
      for (int k = 1; k <= 256; k++) begin
         tick();
         if (k <= PER) h0 += int'(pwm_out[0]);
         g1 += int'(gb_tick);
         g2 += int'(gb_tick2);
         if (gb_tick && first_gb < 0) first_gb = k;
      end
      chk("post_reset_period_low", h0, 0);
      chk("gb_first_pulse_at_4", first_gb, 4);
      chk("gb_inc64_count", g1, 64);
      chk("gb_inc3_count", g2, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
